// File: rtl/hazard_scoreboard.sv
//------------------------------------------------------------------------------
// hazard_scoreboard
//
// Purpose:
//   Register-hazard scoreboard for an in-order issue stage. It keeps a small
//   saturating count of in-flight writers for each architectural register. It
//   decides whether the instruction in ID may issue, and it steers each source
//   operand to an early-forward channel or a retire-bypass channel when exactly
//   one writer is outstanding and that writer's result is visible this cycle.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   iss_valid / iss_ready        issue handshake (fires on valid & ready)
//   iss_rs1/2, iss_rs1/2_valid   source register indices and read enables
//   iss_rd, iss_rd_wen           destination register and write enable
//   fwd_valid, fwd_rd            early-forward channels (index 0 = youngest)
//   ret_valid, ret_rd            writers leaving the pipe (writeback or kill)
//   flush                        discard all in-flight tracking
//   src1/2_fwd_sel               one-hot forward select per source, or zero
//   src1/2_ret_sel               one-hot retire-bypass select per source, or zero
//   busy_vec                     bit i set while register i has a writer in flight
//   stall_cnt                    saturating count of stalled issue cycles
//   err_underflow                sticky: a retire named a register with no writer
//------------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int REG_NUM = 32,
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 2,
    parameter int FWD_CH  = 2,
    parameter int RET_CH  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       iss_valid,
    output logic                       iss_ready,
    input  logic [REG_AW-1:0]          iss_rs1,
    input  logic [REG_AW-1:0]          iss_rs2,
    input  logic                       iss_rs1_valid,
    input  logic                       iss_rs2_valid,
    input  logic [REG_AW-1:0]          iss_rd,
    input  logic                       iss_rd_wen,
    input  logic [FWD_CH-1:0]          fwd_valid,
    input  logic [FWD_CH*REG_AW-1:0]   fwd_rd,
    input  logic [RET_CH-1:0]          ret_valid,
    input  logic [RET_CH*REG_AW-1:0]   ret_rd,
    input  logic                       flush,
    output logic [FWD_CH-1:0]          src1_fwd_sel,
    output logic [FWD_CH-1:0]          src2_fwd_sel,
    output logic [RET_CH-1:0]          src1_ret_sel,
    output logic [RET_CH-1:0]          src2_ret_sel,
    output logic [REG_NUM-1:0]         busy_vec,
    output logic [31:0]                stall_cnt,
    output logic                       err_underflow
);

    // Counter arithmetic is done in a wider domain so that increment and
    // several decrements can be netted without wrapping before the
    // underflow test.
    localparam int SUM_W = CNT_W + $clog2(RET_CH + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
    localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

    //--------------------------------------------------------------------------
    // Helper functions
    //--------------------------------------------------------------------------

    // Forward channels currently holding a valid result for register idx.
    function automatic logic [FWD_CH-1:0] fwd_hits(
        input logic [REG_AW-1:0]        idx,
        input logic [FWD_CH-1:0]        vld,
        input logic [FWD_CH*REG_AW-1:0] rds
    );
        logic [FWD_CH-1:0] h;
        h = '0;
        for (int c = 0; c < FWD_CH; c++) begin
            h[c] = vld[c] & (rds[c*REG_AW +: REG_AW] == idx);
        end
        return h;
    endfunction

    // Retire channels currently releasing register idx.
    function automatic logic [RET_CH-1:0] ret_hits(
        input logic [REG_AW-1:0]        idx,
        input logic [RET_CH-1:0]        vld,
        input logic [RET_CH*REG_AW-1:0] rds
    );
        logic [RET_CH-1:0] h;
        h = '0;
        for (int c = 0; c < RET_CH; c++) begin
            h[c] = vld[c] & (rds[c*REG_AW +: REG_AW] == idx);
        end
        return h;
    endfunction

    // Keep only the lowest set bit of a forward-hit vector.
    function automatic logic [FWD_CH-1:0] fwd_first(input logic [FWD_CH-1:0] v);
        logic [FWD_CH-1:0] o;
        logic              found;
        o     = '0;
        found = 1'b0;
        for (int c = 0; c < FWD_CH; c++) begin
            if (v[c] && !found) begin
                o[c]  = 1'b1;
                found = 1'b1;
            end else begin
                o[c]  = 1'b0;
            end
        end
        return o;
    endfunction

    // Keep only the lowest set bit of a retire-hit vector.
    function automatic logic [RET_CH-1:0] ret_first(input logic [RET_CH-1:0] v);
        logic [RET_CH-1:0] o;
        logic              found;
        o     = '0;
        found = 1'b0;
        for (int c = 0; c < RET_CH; c++) begin
            if (v[c] && !found) begin
                o[c]  = 1'b1;
                found = 1'b1;
            end else begin
                o[c]  = 1'b0;
            end
        end
        return o;
    endfunction

    // Number of retire channels in a hit vector, in the netting width.
    function automatic logic [SUM_W-1:0] ret_count(input logic [RET_CH-1:0] v);
        logic [SUM_W-1:0] n;
        n = '0;
        for (int c = 0; c < RET_CH; c++) begin
            n = n + SUM_W'(v[c]);
        end
        return n;
    endfunction

    //--------------------------------------------------------------------------
    // State
    //--------------------------------------------------------------------------
    logic [REG_NUM-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [REG_NUM-1:0]            busy_q, busy_d;
    logic [31:0]                   stall_cnt_q, stall_cnt_d;
    logic                          err_q, err_d;

    //--------------------------------------------------------------------------
    // Combinational decision signals
    //--------------------------------------------------------------------------
    logic [CNT_W-1:0]  cnt1_s, cnt2_s, cnt_rd_s;
    logic [FWD_CH-1:0] s1_fhit_s, s2_fhit_s;
    logic [RET_CH-1:0] s1_rhit_s, s2_rhit_s, rd_rhit_s;
    logic              s1_haz_s, s2_haz_s, rd_sat_s;
    logic              ready_s, fire_s;
    logic [FWD_CH-1:0] s1_fsel_s, s2_fsel_s;
    logic [RET_CH-1:0] s1_rsel_s, s2_rsel_s;
    logic              underflow_s;
    logic              inc_s;
    logic [SUM_W-1:0]  sum_s, dec_s;

    // Hazard detection, operand steering and issue permission from pre-edge counts.
    always_comb begin
        cnt1_s    = cnt_q[iss_rs1];
        cnt2_s    = cnt_q[iss_rs2];
        cnt_rd_s  = cnt_q[iss_rd];
        s1_fhit_s = fwd_hits(iss_rs1, fwd_valid, fwd_rd);
        s2_fhit_s = fwd_hits(iss_rs2, fwd_valid, fwd_rd);
        s1_rhit_s = ret_hits(iss_rs1, ret_valid, ret_rd);
        s2_rhit_s = ret_hits(iss_rs2, ret_valid, ret_rd);
        rd_rhit_s = ret_hits(iss_rd, ret_valid, ret_rd);

        // A single outstanding writer can be bypassed if it is visible now;
        // two or more leave the youngest writer ambiguous, so always stall.
        s1_haz_s = iss_rs1_valid & (iss_rs1 != REG_ZERO) & (cnt1_s != CNT_ZERO) &
                   ~((cnt1_s == CNT_ONE) & ((|s1_fhit_s) | (|s1_rhit_s)));
        s2_haz_s = iss_rs2_valid & (iss_rs2 != REG_ZERO) & (cnt2_s != CNT_ZERO) &
                   ~((cnt2_s == CNT_ONE) & ((|s2_fhit_s) | (|s2_rhit_s)));

        // A saturated destination counter can still take one more writer when
        // a retire on the same register frees a slot in this cycle.
        rd_sat_s = iss_rd_wen & (iss_rd != REG_ZERO) & (cnt_rd_s == CNT_MAX) & ~(|rd_rhit_s);

        ready_s = ~flush & ~s1_haz_s & ~s2_haz_s & ~rd_sat_s;
        fire_s  = iss_valid & ready_s;

        // Forward path takes priority over retire bypass; selects only drive
        // for a source actually read by a presented instruction.
        if (iss_valid && iss_rs1_valid && (cnt1_s == CNT_ONE)) begin
            s1_fsel_s = fwd_first(s1_fhit_s);
        end else begin
            s1_fsel_s = '0;
        end
        if (iss_valid && iss_rs2_valid && (cnt2_s == CNT_ONE)) begin
            s2_fsel_s = fwd_first(s2_fhit_s);
        end else begin
            s2_fsel_s = '0;
        end
        if (iss_valid && iss_rs1_valid && (cnt1_s == CNT_ONE) && (s1_fsel_s == '0)) begin
            s1_rsel_s = ret_first(s1_rhit_s);
        end else begin
            s1_rsel_s = '0;
        end
        if (iss_valid && iss_rs2_valid && (cnt2_s == CNT_ONE) && (s2_fsel_s == '0)) begin
            s2_rsel_s = ret_first(s2_rhit_s);
        end else begin
            s2_rsel_s = '0;
        end
    end

    // Next-state for counters, busy mirror, stall statistic and error flag.
    always_comb begin
        cnt_d       = cnt_q;
        underflow_s = 1'b0;
        inc_s       = 1'b0;
        sum_s       = '0;
        dec_s       = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            if (flush) begin
                cnt_d[i] = CNT_ZERO;
            end else if (i == 0) begin
                // x0 is hard-wired; never tracked, retires on it are ignored.
                cnt_d[i] = CNT_ZERO;
            end else begin
                inc_s = fire_s & iss_rd_wen & (iss_rd == REG_AW'(i));
                dec_s = ret_count(ret_hits(REG_AW'(i), ret_valid, ret_rd));
                sum_s = SUM_W'(cnt_q[i]) + SUM_W'(inc_s);
                if (sum_s < dec_s) begin
                    cnt_d[i]    = CNT_ZERO;
                    underflow_s = 1'b1;
                end else begin
                    cnt_d[i]    = CNT_W'(sum_s - dec_s);
                end
            end
        end

        for (int i = 0; i < REG_NUM; i++) begin
            busy_d[i] = (cnt_d[i] != CNT_ZERO);
        end

        if (iss_valid && !ready_s && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end

        err_d = err_q | underflow_s;
    end

    // State registers; reset discards all in-flight tracking immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            busy_q      <= '0;
            stall_cnt_q <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

    assign iss_ready     = ready_s;
    assign src1_fwd_sel  = s1_fsel_s;
    assign src2_fwd_sel  = s2_fsel_s;
    assign src1_ret_sel  = s1_rsel_s;
    assign src2_ret_sel  = s2_rsel_s;
    assign busy_vec      = busy_q;
    assign stall_cnt     = stall_cnt_q;
    assign err_underflow = err_q;

endmodule
